prod_accum: RTL and testbench

- Downstream consumer of the 8x8 array multiplier's 16-bit product.
- Registers successive products under a valid/ready handshake and sums a frame of up to LEN products into a wider accumulator.
- Presents each frame total to the next stage through a valid/ready output, turning the combinational multiplier into a sequential dot-product / MAC datapath.

---
 rtl/mul_pkg.sv | 13 +
 rtl/prod_accum_add.sv | 27 ++
 rtl/prod_accum.sv | 95 +++++++++
 tb/tb_prod_accum.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Constants shared by the 8x8 multiplier wrapper and its product accumulator.
package mul_pkg;

  localparam int unsigned MUL_PW = 16;
  localparam int unsigned MUL_AW = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/prod_accum_add.sv
// AW-bit accumulate adder with carry-out.
// PROD_ACCUM_SAT_EN clamps the sum to all-ones on carry-out instead of wrapping.
module prod_accum_add
  import mul_pkg::*;
#(
  parameter int unsigned PW = MUL_PW,
  parameter int unsigned AW = MUL_AW
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] raw;

  assign raw   = {1'b0, acc} + (AW+1)'(prod);
  assign carry = raw[AW];

`ifdef PROD_ACCUM_SAT_EN
  // Once saturated, every later add carries again, so the clamp sticks for the frame.
  assign sum = carry ? {AW{1'b1}} : raw[AW-1:0];
`else
  assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator for multiplier products: sums up to LEN products per frame and
// hands each total downstream over valid/ready. Optional saturation: PROD_ACCUM_SAT_EN.
module prod_accum
  import mul_pkg::*;
#(
  parameter int unsigned PW  = MUL_PW,
  parameter int unsigned AW  = MUL_AW,
  parameter int unsigned LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PW-1:0]              in_prod,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [AW-1:0]              out_sum,
  output logic [$clog2(LEN+1)-1:0]   out_count,
  output logic                       out_ovf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned CW = $clog2(LEN + 1);

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic [AW-1:0] add_sum;
  logic          add_carry;
  logic          accept;
  logic          frame_end;
  logic [CW:0]   cnt_inc;

  prod_accum_add #(
    .PW (PW),
    .AW (AW)
  ) u_add (
    .acc   (acc_q),
    .prod  (in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // cnt_q is zero in IDLE, so the same LEN test covers the LEN=1 case there.
  assign cnt_inc   = {1'b0, cnt_q} + (CW+1)'(1);
  assign frame_end = in_last | (cnt_inc == (CW+1)'(LEN));
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_q   <= AW'(in_prod);
            cnt_q   <= CW'(1);
            ovf_q   <= 1'b0;
            state_q <= frame_end ? ST_HOLD : ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc_q   <= add_sum;
            cnt_q   <= cnt_inc[CW-1:0];
            ovf_q   <= ovf_q | add_carry;
            state_q <= frame_end ? ST_HOLD : ST_ACC;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // in_ready is a state decode; rst only masks it so nothing is taken while in reset.
  assign in_ready  = ~rst & (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: default build, a 16-bit accumulator instance and a LEN=1 instance.
module tb_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      vld, lst, ordy;
  logic [2:0][15:0] prod;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
  logic [23:0] sum0, sum2;
  logic [15:0] sum1;
  logic [3:0]  cnt0, cnt1;
  logic        cnt2;

  logic [2:0]       rdy_w, ov_w, ovf_w;
  logic [2:0][23:0] sum_w;
  logic [2:0][3:0]  cnt_w;

  assign rdy_w = {rdy2, rdy1, rdy0};
  assign ov_w  = {ov2, ov1, ov0};
  assign ovf_w = {of2, of1, of0};
  assign sum_w = {sum2, 24'(sum1), sum0};
  assign cnt_w = {{3'd0, cnt2}, cnt1, cnt0};

  prod_accum #(.PW(16), .AW(24), .LEN(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_prod(prod[0]), .in_valid(vld[0]), .in_last(lst[0]),
    .in_ready(rdy0), .out_sum(sum0), .out_count(cnt0), .out_ovf(of0),
    .out_valid(ov0), .out_ready(ordy[0])
  );

  prod_accum #(.PW(16), .AW(16), .LEN(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_prod(prod[1]), .in_valid(vld[1]), .in_last(lst[1]),
    .in_ready(rdy1), .out_sum(sum1), .out_count(cnt1), .out_ovf(of1),
    .out_valid(ov1), .out_ready(ordy[1])
  );

  prod_accum #(.PW(16), .AW(24), .LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_prod(prod[2]), .in_valid(vld[2]), .in_last(lst[2]),
    .in_ready(rdy2), .out_sum(sum2), .out_count(cnt2), .out_ovf(of2),
    .out_valid(ov2), .out_ready(ordy[2])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input int i, input logic [15:0] p, input logic l, output int w);
    w = 0;
    prod[i] = p;
    lst[i]  = l;
    vld[i]  = 1'b1;
    #1;
    while (!rdy_w[i] && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("push_ready_seen", 32'(rdy_w[i]), 1);
    @(negedge clk);
    vld[i] = 1'b0;
    lst[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input int n, input logic [7:0][15:0] p,
                           input logic use_last, input logic [23:0] es, input int ec,
                           input logic eo, input string tag);
    int w;
    for (int k = 0; k < n; k++) push(i, p[k], use_last && (k == n - 1), w);
    chk({tag, "_valid"}, 32'(ov_w[i]), 1);
    chk({tag, "_sum"}, 32'(sum_w[i]), 32'(es));
    chk({tag, "_count"}, 32'(cnt_w[i]), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf_w[i]), 32'(eo));
    chk({tag, "_hold_ready"}, 32'(rdy_w[i]), 0);
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(ov_w[i]), 0);
    chk({tag, "_done_ready"}, 32'(rdy_w[i]), 1);
  endtask

  typedef struct {
    int               n;
    logic [7:0][15:0] p;
    logic             last;
    logic [23:0]      sum;
    int               cnt;
  } vec_t;

  typedef struct {
    longint sum;
    int     cnt;
    logic   ovf;
  } res_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int               w;
    logic [7:0][15:0] pp;
    res_t             q[$];
    longint           cur;
    int               cur_n;
    logic             v, l, r, o, rd;
    logic [15:0]      p;

    rst  = 1'b1;
    vld  = '0;
    lst  = '0;
    ordy = '1;
    prod = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy_w[0]), 0);
    chk("rst_valid", 32'(ov_w[0]), 0);
    chk("rst_sum", 32'(sum_w[0]), 0);
    chk("rst_count", 32'(cnt_w[0]), 0);
    chk("rst_ovf", 32'(ovf_w[0]), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(rdy_w[0]), 1);
    @(negedge clk);

    vecs[0].n = 8; vecs[0].last = 1'b0; vecs[0].sum = 24'd105000; vecs[0].cnt = 8;
    vecs[1].n = 8; vecs[1].last = 1'b1; vecs[1].sum = 24'd524280; vecs[1].cnt = 8;
    vecs[2].n = 1; vecs[2].last = 1'b1; vecs[2].sum = 24'd42;     vecs[2].cnt = 1;
    vecs[3].n = 8; vecs[3].last = 1'b0; vecs[3].sum = 24'd36;     vecs[3].cnt = 8;
    vecs[4].n = 2; vecs[4].last = 1'b1; vecs[4].sum = 24'd0;      vecs[4].cnt = 2;
    for (int k = 0; k < 8; k++) begin
      vecs[0].p[k] = 16'd13125;
      vecs[1].p[k] = 16'hffff;
      vecs[2].p[k] = 16'd42;
      vecs[3].p[k] = 16'(k + 1);
      vecs[4].p[k] = 16'd0;
    end
    for (int v_i = 0; v_i < 5; v_i++)
      run_frame(0, vecs[v_i].n, vecs[v_i].p, vecs[v_i].last, vecs[v_i].sum, vecs[v_i].cnt,
                1'b0, $sformatf("vec%0d", v_i));

    // 100,200,300 then the next frame must start the cycle after the transfer.
    push(0, 16'd100, 1'b0, w);
    push(0, 16'd200, 1'b0, w);
    push(0, 16'd300, 1'b1, w);
    chk("f600_valid", 32'(ov_w[0]), 1);
    chk("f600_sum", 32'(sum_w[0]), 600);
    chk("f600_count", 32'(cnt_w[0]), 3);
    chk("f600_ready", 32'(rdy_w[0]), 0);
    push(0, 16'd1000, 1'b0, w);
    chk("next_frame_wait", 32'(w), 1);
    ordy[0] = 1'b0;
    push(0, 16'd2000, 1'b1, w);
    chk("second_prod_wait", 32'(w), 0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(ov_w[0]), 1);
      chk("stall_ready", 32'(rdy_w[0]), 0);
      chk("stall_sum", 32'(sum_w[0]), 3000);
      chk("stall_count", 32'(cnt_w[0]), 2);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    chk("stall_c6_valid", 32'(ov_w[0]), 1);
    @(negedge clk);
    chk("stall_after_valid", 32'(ov_w[0]), 0);
    chk("stall_after_ready", 32'(rdy_w[0]), 1);
    chk("stall_after_count", 32'(cnt_w[0]), 0);

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 3; k++) push(0, 16'd500, 1'b0, w);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sum", 32'(sum_w[0]), 0);
    chk("midrst_count", 32'(cnt_w[0]), 0);
    chk("midrst_valid", 32'(ov_w[0]), 0);
    chk("midrst_ready", 32'(rdy_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    pp = '0;
    pp[0] = 16'd5; pp[1] = 16'd7; pp[2] = 16'd9;
    run_frame(0, 3, pp, 1'b1, 24'd21, 3, 1'b0, "fresh");

    // 16-bit accumulator: wrap or clamp on carry-out.
    pp = '0;
    pp[0] = 16'd40000; pp[1] = 16'd40000;
`ifdef PROD_ACCUM_SAT_EN
    run_frame(1, 2, pp, 1'b1, 24'd65535, 2, 1'b1, "ovf2");
`else
    run_frame(1, 2, pp, 1'b1, 24'd14464, 2, 1'b1, "ovf2");
`endif
    pp[0] = 16'hffff; pp[1] = 16'hffff; pp[2] = 16'hffff;
`ifdef PROD_ACCUM_SAT_EN
    run_frame(1, 3, pp, 1'b1, 24'd65535, 3, 1'b1, "ovf3");
`else
    run_frame(1, 3, pp, 1'b1, 24'd65533, 3, 1'b1, "ovf3");
`endif

    // LEN=1: every product is its own frame.
    pp = '0;
    pp[0] = 16'd9;
    run_frame(2, 1, pp, 1'b0, 24'd9, 1, 1'b0, "len1_a");
    pp[0] = 16'd4;
    run_frame(2, 1, pp, 1'b0, 24'd4, 1, 1'b0, "len1_b");

    // Random traffic against a frame-level model.
    cur   = 0;
    cur_n = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      o  = ov_w[0];
      rd = rdy_w[0];
      chk("rnd_valid", 32'(o), 32'(q.size() != 0));
      chk("rnd_ready", 32'(rd), 32'(q.size() == 0));
      if (o && q.size() != 0) begin
        chk("rnd_sum", 32'(sum_w[0]), 32'(q[0].sum));
        chk("rnd_count", 32'(cnt_w[0]), 32'(q[0].cnt));
        chk("rnd_ovf", 32'(ovf_w[0]), 32'(q[0].ovf));
      end
      v = ($urandom % 4) != 0;
      l = ($urandom % 6) == 0;
      r = ($urandom % 3) != 0;
      p = (($urandom % 5) == 0) ? 16'hffff : 16'($urandom);
      vld[0]  = v;
      lst[0]  = l;
      ordy[0] = r;
      prod[0] = p;
      if (o && r && q.size() != 0) void'(q.pop_front());
      if (v && rd) begin
        cur += longint'(p);
        cur_n++;
        if (l || cur_n == 8) begin
          q.push_back('{cur % (64'd1 << 24), cur_n, cur >= (64'd1 << 24)});
          cur   = 0;
          cur_n = 0;
        end
      end
      @(negedge clk);
    end
    vld[0]  = 1'b0;
    ordy[0] = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
